// File: rtl/dtw_accel_pkg.sv
// Shared definitions for the DTW accelerator scheduler.
// Holds the FSM state encoding and default datapath widths.
// No logic. Imported by the scheduler and its sample stage.
package dtw_accel_pkg;

    localparam int DEF_SAMPLE_WIDTH = 8;
    localparam int DEF_QLEN_WIDTH   = 16;
    localparam int DEF_SCORE_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH     = 2'd1,
        WAIT_DONE = 2'd2,
        REPORT    = 2'd3
    } state_t;

endpackage

// File: rtl/dtw_accel_sched_sample_reg.sv
// One-entry valid/ready pipeline register carrying a sample word and its last flag.
// Latency: one cycle from push to presentation on the smp side.
// Backpressure: accepts a new word when empty or when the held word drains in the same cycle.
module dtw_sample_reg
    import dtw_accel_pkg::*;
#(
    parameter int WIDTH = DEF_SAMPLE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    output logic             push_ready,
    output logic             smp_valid,
    output logic [WIDTH-1:0] smp_data,
    output logic             smp_last,
    input  logic             smp_ready
);

    assign push_ready = !smp_valid || smp_ready;

    // Stage register: flush beats load so a cancelled run leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            smp_valid <= 1'b0;
            smp_data  <= '0;
            smp_last  <= 1'b0;
        end else if (push_valid && push_ready) begin
            smp_valid <= 1'b1;
            smp_data  <= push_data;
            smp_last  <= push_last;
        end else if (smp_ready) begin
            smp_valid <= 1'b0;
            smp_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/dtw_accel_sched.sv
// Schedules one DTW query: pops qlen samples from a FWFT FIFO into the core, then returns its score.
// Latency: one register stage between FIFO pop and core sample; score held from core_done until res_ready.
// Backpressure: pops stall on FIFO empty or a full, unaccepted sample stage; result waits on res_ready.
module dtw_accel_sched
    import dtw_accel_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int QLEN_WIDTH   = DEF_QLEN_WIDTH,
    parameter int SCORE_WIDTH  = DEF_SCORE_WIDTH
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [QLEN_WIDTH-1:0]   cfg_qlen,
    input  logic                    cfg_start,
    input  logic                    cfg_abort,
    output logic                    dtw_fifo_rden,
    input  logic [SAMPLE_WIDTH-1:0] dtw_fifo_dout,
    input  logic                    dtw_fifo_empty,
    output logic                    core_start,
    output logic                    core_smp_valid,
    output logic [SAMPLE_WIDTH-1:0] core_smp_data,
    output logic                    core_smp_last,
    input  logic                    core_smp_ready,
    input  logic                    core_done,
    input  logic [SCORE_WIDTH-1:0]  core_score,
    output logic                    res_valid,
    output logic [SCORE_WIDTH-1:0]  res_score,
    input  logic                    res_ready,
    output logic                    busy,
    output logic                    err_qlen,
    output logic [15:0]             run_count
);

    state_t                state, state_nxt;
    logic [QLEN_WIDTH-1:0] qlen_q;
    logic [QLEN_WIDTH-1:0] pop_cnt;
    logic                  stage_ready;
    logic                  start_ok;
    logic                  abort_hit;
    logic                  last_acc;
    logic                  done_hit;
    logic                  res_hs;
    logic                  pop_last;

    assign start_ok  = (state == IDLE) && cfg_start && (cfg_qlen != '0);
    assign abort_hit = cfg_abort && ((state == FETCH) || (state == WAIT_DONE));
    assign last_acc  = core_smp_valid && core_smp_ready && core_smp_last;
    assign done_hit  = (state == WAIT_DONE) && core_done && !cfg_abort;
    assign res_hs    = (state == REPORT) && res_ready;
    assign pop_last  = (pop_cnt == qlen_q - 1'b1);
    assign busy      = (state != IDLE);
    assign res_valid = (state == REPORT);

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and pop strobe; popping is also blocked while reset is held.
    always_comb begin
        state_nxt     = state;
        dtw_fifo_rden = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = FETCH;
            end
            FETCH: begin
                dtw_fifo_rden = !ARESET && !dtw_fifo_empty && (pop_cnt < qlen_q) && stage_ready;
                if (cfg_abort)     state_nxt = IDLE;
                else if (last_acc) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (cfg_abort)      state_nxt = IDLE;
                else if (core_done) state_nxt = REPORT;
            end
            REPORT: begin
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Run bookkeeping: query length, pop count, start pulse, error flag, score and run counter.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            qlen_q     <= '0;
            pop_cnt    <= '0;
            core_start <= 1'b0;
            err_qlen   <= 1'b0;
            res_score  <= '0;
            run_count  <= '0;
        end else begin
            core_start <= start_ok;
            if (start_ok) begin
                qlen_q   <= cfg_qlen;
                pop_cnt  <= '0;
                err_qlen <= 1'b0;
            end else if ((state == IDLE) && cfg_start) begin
                err_qlen <= 1'b1;
            end
            if (dtw_fifo_rden) pop_cnt   <= pop_cnt + 1'b1;
            if (done_hit)      res_score <= core_score;
            if (res_hs)        run_count <= run_count + 16'd1;
        end
    end

    dtw_sample_reg #(
        .WIDTH (SAMPLE_WIDTH)
    ) u_sample_reg (
        .clk        (ACLK),
        .rst        (ARESET),
        .flush      (abort_hit),
        .push_valid (dtw_fifo_rden),
        .push_data  (dtw_fifo_dout),
        .push_last  (pop_last),
        .push_ready (stage_ready),
        .smp_valid  (core_smp_valid),
        .smp_data   (core_smp_data),
        .smp_last   (core_smp_last),
        .smp_ready  (core_smp_ready)
    );

endmodule

// File: tb/tb_dtw_accel_sched.sv
// Directed bench for dtw_accel_sched with a FWFT FIFO model and a scripted core.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// Edge monitors record pops, start pulses, accepted samples and stability of stalled data.
module tb_dtw_accel_sched;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [15:0] cfg_qlen;
    logic        cfg_start;
    logic        cfg_abort;
    logic        dtw_fifo_rden;
    logic [7:0]  dtw_fifo_dout;
    logic        dtw_fifo_empty;
    logic        core_start;
    logic        core_smp_valid;
    logic [7:0]  core_smp_data;
    logic        core_smp_last;
    logic        core_smp_ready;
    logic        core_done;
    logic [31:0] core_score;
    logic        res_valid;
    logic [31:0] res_score;
    logic        res_ready;
    logic        busy;
    logic        err_qlen;
    logic [15:0] run_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mem [0:31];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops = 0, starts = 0, bad_rden = 0, unstable = 0, cap_n = 0;
    logic [7:0] cap_d [0:63];
    logic       cap_l [0:63];
    logic       hold_vld = 1'b0;
    logic [7:0] hold_dat = 8'h00;

    always #5 ACLK = ~ACLK;

    assign dtw_fifo_empty = (rd_ptr == wr_ptr);
    assign dtw_fifo_dout  = mem[rd_ptr[4:0]];

    dtw_accel_sched dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .cfg_qlen       (cfg_qlen),
        .cfg_start      (cfg_start),
        .cfg_abort      (cfg_abort),
        .dtw_fifo_rden  (dtw_fifo_rden),
        .dtw_fifo_dout  (dtw_fifo_dout),
        .dtw_fifo_empty (dtw_fifo_empty),
        .core_start     (core_start),
        .core_smp_valid (core_smp_valid),
        .core_smp_data  (core_smp_data),
        .core_smp_last  (core_smp_last),
        .core_smp_ready (core_smp_ready),
        .core_done      (core_done),
        .core_score     (core_score),
        .res_valid      (res_valid),
        .res_score      (res_score),
        .res_ready      (res_ready),
        .busy           (busy),
        .err_qlen       (err_qlen),
        .run_count      (run_count)
    );

    // FIFO pop side plus monitors of core-facing traffic.
    always @(posedge ACLK) begin
        if (dtw_fifo_rden) begin
            pops   <= pops + 1;
            rd_ptr <= rd_ptr + 1;
            if (dtw_fifo_empty) bad_rden <= bad_rden + 1;
        end
        if (core_start) starts <= starts + 1;
        if (core_smp_valid && core_smp_ready) begin
            cap_d[cap_n[5:0]] <= core_smp_data;
            cap_l[cap_n[5:0]] <= core_smp_last;
            cap_n <= cap_n + 1;
        end
        if (core_smp_valid && !core_smp_ready) begin
            if (hold_vld && core_smp_data !== hold_dat) unstable <= unstable + 1;
            hold_vld <= 1'b1;
            hold_dat <= core_smp_data;
        end else begin
            hold_vld <= 1'b0;
        end
    end

    task automatic push(input logic [7:0] v);
        mem[wr_ptr[4:0]] = v;
        wr_ptr++;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    task automatic start_run(input logic [15:0] q);
        cfg_qlen  = q;
        cfg_start = 1'b1;
        @(negedge ACLK);
        cfg_start = 1'b0;
    endtask

    task automatic finish_run(input logic [31:0] s);
        core_score = s;
        core_done  = 1'b1;
        @(negedge ACLK);
        core_done  = 1'b0;
        res_ready  = 1'b1;
        @(negedge ACLK);
        res_ready  = 1'b0;
    endtask

    task automatic test_reset;
        ARESET = 1'b1;
        cyc(3);
        vectors++; if (dtw_fifo_rden !== 1'b0)  begin miscompares++; $display("FAIL rst_rden got %0h want 0", dtw_fifo_rden); end
        vectors++; if (core_start !== 1'b0)     begin miscompares++; $display("FAIL rst_core_start got %0h want 0", core_start); end
        vectors++; if (core_smp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_smp_valid got %0h want 0", core_smp_valid); end
        vectors++; if (core_smp_data !== 8'h00) begin miscompares++; $display("FAIL rst_smp_data got %0h want 0", core_smp_data); end
        vectors++; if (core_smp_last !== 1'b0)  begin miscompares++; $display("FAIL rst_smp_last got %0h want 0", core_smp_last); end
        vectors++; if (res_valid !== 1'b0)      begin miscompares++; $display("FAIL rst_res_valid got %0h want 0", res_valid); end
        vectors++; if (res_score !== 32'h0)     begin miscompares++; $display("FAIL rst_res_score got %0h want 0", res_score); end
        vectors++; if (busy !== 1'b0)           begin miscompares++; $display("FAIL rst_busy got %0h want 0", busy); end
        vectors++; if (err_qlen !== 1'b0)       begin miscompares++; $display("FAIL rst_err_qlen got %0h want 0", err_qlen); end
        vectors++; if (run_count !== 16'h0)     begin miscompares++; $display("FAIL rst_run_count got %0h want 0", run_count); end
        ARESET = 1'b0;
        cyc(1);
    endtask

    task automatic test_basic_stream;
        logic [7:0] ex [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int b = cap_n, p = pops, s = starts;
        core_smp_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(ex[i]);
        start_run(16'd4);
        vectors++; if (core_start !== 1'b1) begin miscompares++; $display("FAIL basic_start_pulse got %0h want 1", core_start); end
        cyc(1);
        vectors++; if (core_start !== 1'b0) begin miscompares++; $display("FAIL basic_start_drop got %0h want 0", core_start); end
        cyc(6);
        vectors++; if (cap_n - b !== 4) begin miscompares++; $display("FAIL basic_count got %0d want 4", cap_n - b); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (cap_d[b+i] !== ex[i]) begin miscompares++; $display("FAIL basic_data[%0d] got %0h want %0h", i, cap_d[b+i], ex[i]); end
            vectors++; if (cap_l[b+i] !== (i == 3)) begin miscompares++; $display("FAIL basic_last[%0d] got %0h want %0h", i, cap_l[b+i], (i == 3)); end
        end
        vectors++; if (pops - p !== 4)          begin miscompares++; $display("FAIL basic_pops got %0d want 4", pops - p); end
        vectors++; if (starts - s !== 1)        begin miscompares++; $display("FAIL basic_starts got %0d want 1", starts - s); end
        vectors++; if (busy !== 1'b1)           begin miscompares++; $display("FAIL basic_wait_busy got %0h want 1", busy); end
        vectors++; if (core_smp_valid !== 1'b0) begin miscompares++; $display("FAIL basic_wait_valid got %0h want 0", core_smp_valid); end
    endtask

    task automatic test_report;
        core_score = 32'h0000_1234;
        core_done  = 1'b1;
        res_ready  = 1'b0;
        @(negedge ACLK);
        core_done  = 1'b0;
        core_score = 32'h0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (res_valid !== 1'b1)         begin miscompares++; $display("FAIL rep_valid[%0d] got %0h want 1", i, res_valid); end
            vectors++; if (res_score !== 32'h1234)     begin miscompares++; $display("FAIL rep_score[%0d] got %0h want 1234", i, res_score); end
            vectors++; if (run_count !== 16'd0)        begin miscompares++; $display("FAIL rep_count_hold[%0d] got %0d want 0", i, run_count); end
            if (i < 2) @(negedge ACLK);
        end
        res_ready = 1'b1;
        @(negedge ACLK);
        res_ready = 1'b0;
        vectors++; if (run_count !== 16'd1) begin miscompares++; $display("FAIL rep_count_inc got %0d want 1", run_count); end
        vectors++; if (res_valid !== 1'b0)  begin miscompares++; $display("FAIL rep_valid_drop got %0h want 0", res_valid); end
        vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL rep_idle_busy got %0h want 0", busy); end
        core_score = 32'hDEAD;
        core_done  = 1'b1;
        @(negedge ACLK);
        core_done  = 1'b0;
        vectors++; if (res_valid !== 1'b0)      begin miscompares++; $display("FAIL idle_done_valid got %0h want 0", res_valid); end
        vectors++; if (res_score !== 32'h1234)  begin miscompares++; $display("FAIL idle_done_score got %0h want 1234", res_score); end
    endtask

    task automatic test_fifo_empty;
        logic [7:0] ex [3] = '{8'hA1, 8'hA2, 8'hA3};
        int b = cap_n, p = pops, s = starts, br = bad_rden;
        push(8'hA1);
        start_run(16'd3);
        cfg_qlen  = 16'd9;
        cfg_start = 1'b1;
        @(negedge ACLK);
        cfg_start = 1'b0;
        cyc(5);
        push(8'hA2);
        push(8'hA3);
        cyc(8);
        vectors++; if (cap_n - b !== 3) begin miscompares++; $display("FAIL gap_count got %0d want 3", cap_n - b); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (cap_d[b+i] !== ex[i]) begin miscompares++; $display("FAIL gap_data[%0d] got %0h want %0h", i, cap_d[b+i], ex[i]); end
            vectors++; if (cap_l[b+i] !== (i == 2)) begin miscompares++; $display("FAIL gap_last[%0d] got %0h want %0h", i, cap_l[b+i], (i == 2)); end
        end
        vectors++; if (pops - p !== 3)     begin miscompares++; $display("FAIL gap_pops got %0d want 3", pops - p); end
        vectors++; if (bad_rden - br !== 0) begin miscompares++; $display("FAIL gap_rden_empty got %0d want 0", bad_rden - br); end
        vectors++; if (starts - s !== 1)   begin miscompares++; $display("FAIL gap_restart_ignored got %0d want 1", starts - s); end
        vectors++; if (busy !== 1'b1)      begin miscompares++; $display("FAIL gap_busy got %0h want 1", busy); end
        finish_run(32'h55);
        vectors++; if (run_count !== 16'd2) begin miscompares++; $display("FAIL gap_run_count got %0d want 2", run_count); end
    endtask

    task automatic test_stall;
        int b = cap_n, p = pops, u = unstable;
        core_smp_ready = 1'b0;
        push(8'hB1);
        push(8'hB2);
        start_run(16'd2);
        @(negedge ACLK);
        for (int i = 0; i < 4; i++) begin
            vectors++; if (core_smp_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d] got %0h want 1", i, core_smp_valid); end
            vectors++; if (core_smp_data !== 8'hB1) begin miscompares++; $display("FAIL stall_data[%0d] got %0h want b1", i, core_smp_data); end
            vectors++; if (core_smp_last !== 1'b0)  begin miscompares++; $display("FAIL stall_last[%0d] got %0h want 0", i, core_smp_last); end
            vectors++; if (pops - p !== 1)          begin miscompares++; $display("FAIL stall_pops[%0d] got %0d want 1", i, pops - p); end
            @(negedge ACLK);
        end
        core_smp_ready = 1'b1;
        cyc(4);
        vectors++; if (cap_n - b !== 2)          begin miscompares++; $display("FAIL stall_count got %0d want 2", cap_n - b); end
        vectors++; if (cap_d[b] !== 8'hB1)       begin miscompares++; $display("FAIL stall_order0 got %0h want b1", cap_d[b]); end
        vectors++; if (cap_d[b+1] !== 8'hB2)     begin miscompares++; $display("FAIL stall_order1 got %0h want b2", cap_d[b+1]); end
        vectors++; if (cap_l[b+1] !== 1'b1)      begin miscompares++; $display("FAIL stall_last_end got %0h want 1", cap_l[b+1]); end
        vectors++; if (pops - p !== 2)           begin miscompares++; $display("FAIL stall_pops_total got %0d want 2", pops - p); end
        vectors++; if (unstable - u !== 0)       begin miscompares++; $display("FAIL stall_stability got %0d want 0", unstable - u); end
        finish_run(32'h66);
        vectors++; if (run_count !== 16'd3) begin miscompares++; $display("FAIL stall_run_count got %0d want 3", run_count); end
    endtask

    task automatic test_qlen_zero;
        int s = starts;
        start_run(16'd0);
        vectors++; if (err_qlen !== 1'b1)   begin miscompares++; $display("FAIL zero_err got %0h want 1", err_qlen); end
        vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL zero_busy got %0h want 0", busy); end
        vectors++; if (core_start !== 1'b0) begin miscompares++; $display("FAIL zero_core_start got %0h want 0", core_start); end
        cyc(2);
        vectors++; if (err_qlen !== 1'b1)   begin miscompares++; $display("FAIL zero_err_sticky got %0h want 1", err_qlen); end
        vectors++; if (starts - s !== 0)    begin miscompares++; $display("FAIL zero_starts got %0d want 0", starts - s); end
        push(8'hC1);
        start_run(16'd1);
        vectors++; if (err_qlen !== 1'b0)   begin miscompares++; $display("FAIL zero_err_clear got %0h want 0", err_qlen); end
        vectors++; if (busy !== 1'b1)       begin miscompares++; $display("FAIL zero_next_busy got %0h want 1", busy); end
        vectors++; if (core_start !== 1'b1) begin miscompares++; $display("FAIL zero_next_start got %0h want 1", core_start); end
        cyc(4);
        finish_run(32'h77);
        vectors++; if (run_count !== 16'd4) begin miscompares++; $display("FAIL zero_run_count got %0d want 4", run_count); end
    endtask

    task automatic test_abort_reset;
        int p = pops;
        int p0;
        core_smp_ready = 1'b1;
        push(8'hD1);
        push(8'hD2);
        start_run(16'd8);
        cyc(6);
        vectors++; if (pops - p !== 2) begin miscompares++; $display("FAIL abort_pops got %0d want 2", pops - p); end
        vectors++; if (busy !== 1'b1)  begin miscompares++; $display("FAIL abort_pre_busy got %0h want 1", busy); end
        cfg_abort = 1'b1;
        @(negedge ACLK);
        cfg_abort = 1'b0;
        vectors++; if (busy !== 1'b0)           begin miscompares++; $display("FAIL abort_busy got %0h want 0", busy); end
        vectors++; if (core_smp_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid got %0h want 0", core_smp_valid); end
        vectors++; if (res_valid !== 1'b0)      begin miscompares++; $display("FAIL abort_res_valid got %0h want 0", res_valid); end
        vectors++; if (run_count !== 16'd4)     begin miscompares++; $display("FAIL abort_run_count got %0d want 4", run_count); end
        core_smp_ready = 1'b0;
        p = pops;
        push(8'hE1);
        push(8'hE2);
        start_run(16'd8);
        cyc(2);
        vectors++; if (core_smp_valid !== 1'b1) begin miscompares++; $display("FAIL mid_valid got %0h want 1", core_smp_valid); end
        vectors++; if (pops - p !== 1)          begin miscompares++; $display("FAIL mid_pops got %0d want 1", pops - p); end
        p0 = pops;
        ARESET = 1'b1;
        cyc(2);
        vectors++; if (pops !== p0)             begin miscompares++; $display("FAIL mrst_no_pop got %0d want %0d", pops, p0); end
        vectors++; if (dtw_fifo_rden !== 1'b0)  begin miscompares++; $display("FAIL mrst_rden got %0h want 0", dtw_fifo_rden); end
        vectors++; if (core_start !== 1'b0)     begin miscompares++; $display("FAIL mrst_core_start got %0h want 0", core_start); end
        vectors++; if (core_smp_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_smp_valid got %0h want 0", core_smp_valid); end
        vectors++; if (core_smp_data !== 8'h00) begin miscompares++; $display("FAIL mrst_smp_data got %0h want 0", core_smp_data); end
        vectors++; if (core_smp_last !== 1'b0)  begin miscompares++; $display("FAIL mrst_smp_last got %0h want 0", core_smp_last); end
        vectors++; if (res_valid !== 1'b0)      begin miscompares++; $display("FAIL mrst_res_valid got %0h want 0", res_valid); end
        vectors++; if (res_score !== 32'h0)     begin miscompares++; $display("FAIL mrst_res_score got %0h want 0", res_score); end
        vectors++; if (busy !== 1'b0)           begin miscompares++; $display("FAIL mrst_busy got %0h want 0", busy); end
        vectors++; if (err_qlen !== 1'b0)       begin miscompares++; $display("FAIL mrst_err_qlen got %0h want 0", err_qlen); end
        vectors++; if (run_count !== 16'h0)     begin miscompares++; $display("FAIL mrst_run_count got %0h want 0", run_count); end
        ARESET = 1'b0;
        cyc(1);
    endtask

    initial begin
        ARESET         = 1'b1;
        cfg_qlen       = 16'd0;
        cfg_start      = 1'b0;
        cfg_abort      = 1'b0;
        core_smp_ready = 1'b1;
        core_done      = 1'b0;
        core_score     = 32'h0;
        res_ready      = 1'b0;
        test_reset();
        test_basic_stream();
        test_report();
        test_fifo_empty();
        test_stall();
        test_qlen_zero();
        test_abort_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
